// File: rtl/lcd_rd_arb.sv
// Two-port AXI4 read arbiter: LCD refresh fetch (port 0, priority) and a secondary
// requester (port 1, starvation-guarded) share one master read port, one burst at a time.
module lcd_rd_arb #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic              AXI_ACLK,
   input  logic              AXI_ARESETN,
   input  logic [ADDR_W-1:0] S0_AXI_ARADDR,
   input  logic [7:0]        S0_AXI_ARLEN,
   input  logic [2:0]        S0_AXI_ARSIZE,
   input  logic [1:0]        S0_AXI_ARBURST,
   input  logic [3:0]        S0_AXI_ARCACHE,
   input  logic              S0_AXI_ARVALID,
   output logic              S0_AXI_ARREADY,
   output logic [DATA_W-1:0] S0_AXI_RDATA,
   output logic [1:0]        S0_AXI_RRESP,
   output logic              S0_AXI_RLAST,
   output logic              S0_AXI_RVALID,
   input  logic              S0_AXI_RREADY,
   input  logic [ADDR_W-1:0] S1_AXI_ARADDR,
   input  logic [7:0]        S1_AXI_ARLEN,
   input  logic [2:0]        S1_AXI_ARSIZE,
   input  logic [1:0]        S1_AXI_ARBURST,
   input  logic [3:0]        S1_AXI_ARCACHE,
   input  logic              S1_AXI_ARVALID,
   output logic              S1_AXI_ARREADY,
   output logic [DATA_W-1:0] S1_AXI_RDATA,
   output logic [1:0]        S1_AXI_RRESP,
   output logic              S1_AXI_RLAST,
   output logic              S1_AXI_RVALID,
   input  logic              S1_AXI_RREADY,
   output logic [ADDR_W-1:0] M_AXI_ARADDR,
   output logic [7:0]        M_AXI_ARLEN,
   output logic [2:0]        M_AXI_ARSIZE,
   output logic [1:0]        M_AXI_ARBURST,
   output logic [3:0]        M_AXI_ARCACHE,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   input  logic [DATA_W-1:0] M_AXI_RDATA,
   input  logic [1:0]        M_AXI_RRESP,
   input  logic              M_AXI_RLAST,
   input  logic              M_AXI_RVALID,
   output logic              M_AXI_RREADY,
   output logic [1:0]        grant,
   output logic              busy
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t        state, state_nxt;
   logic [1:0]    grant_nxt;
   logic          win0, win1;
   logic          starved;
   logic [CW-1:0] wait_cnt;

   always_comb begin
      starved        = (wait_cnt >= CW'(MAX_WAIT));
      win0           = 1'b0;
      win1           = 1'b0;
      state_nxt      = state;
      grant_nxt      = grant;
      S0_AXI_ARREADY = 1'b0;
      S1_AXI_ARREADY = 1'b0;
      S0_AXI_RVALID  = 1'b0;
      S0_AXI_RDATA   = '0;
      S0_AXI_RRESP   = '0;
      S0_AXI_RLAST   = 1'b0;
      S1_AXI_RVALID  = 1'b0;
      S1_AXI_RDATA   = '0;
      S1_AXI_RRESP   = '0;
      S1_AXI_RLAST   = 1'b0;
      M_AXI_RREADY   = 1'b0;
      M_AXI_ARVALID  = (state == ADDR);
      busy           = (state != IDLE);
      case (state)
         IDLE: begin
            // A starved port 1 overrides port 0's real-time priority
            if (S1_AXI_ARVALID && starved) win1 = 1'b1;
            else if (S0_AXI_ARVALID)       win0 = 1'b1;
            else if (S1_AXI_ARVALID)       win1 = 1'b1;
            S0_AXI_ARREADY = win0;
            S1_AXI_ARREADY = win1;
            if (win0 || win1) begin
               state_nxt = ADDR;
               grant_nxt = {win1, win0};
            end
         end
         ADDR: begin
            if (M_AXI_ARREADY) state_nxt = DATA;
         end
         DATA: begin
            if (grant[0]) begin
               S0_AXI_RVALID = M_AXI_RVALID;
               S0_AXI_RDATA  = M_AXI_RDATA;
               S0_AXI_RRESP  = M_AXI_RRESP;
               S0_AXI_RLAST  = M_AXI_RLAST;
               M_AXI_RREADY  = S0_AXI_RREADY;
            end else if (grant[1]) begin
               S1_AXI_RVALID = M_AXI_RVALID;
               S1_AXI_RDATA  = M_AXI_RDATA;
               S1_AXI_RRESP  = M_AXI_RRESP;
               S1_AXI_RLAST  = M_AXI_RLAST;
               M_AXI_RREADY  = S1_AXI_RREADY;
            end
            if (M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST) begin
               state_nxt = IDLE;
               grant_nxt = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         state         <= IDLE;
         grant         <= '0;
         M_AXI_ARADDR  <= '0;
         M_AXI_ARLEN   <= '0;
         M_AXI_ARSIZE  <= '0;
         M_AXI_ARBURST <= '0;
         M_AXI_ARCACHE <= '0;
         wait_cnt      <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         if (win0) begin
            M_AXI_ARADDR  <= S0_AXI_ARADDR;
            M_AXI_ARLEN   <= S0_AXI_ARLEN;
            M_AXI_ARSIZE  <= S0_AXI_ARSIZE;
            M_AXI_ARBURST <= S0_AXI_ARBURST;
            M_AXI_ARCACHE <= S0_AXI_ARCACHE;
         end else if (win1) begin
            M_AXI_ARADDR  <= S1_AXI_ARADDR;
            M_AXI_ARLEN   <= S1_AXI_ARLEN;
            M_AXI_ARSIZE  <= S1_AXI_ARSIZE;
            M_AXI_ARBURST <= S1_AXI_ARBURST;
            M_AXI_ARCACHE <= S1_AXI_ARCACHE;
         end
         if (!S1_AXI_ARVALID || S1_AXI_ARREADY) wait_cnt <= '0;
         else if (!starved)                     wait_cnt <= wait_cnt + CW'(1);
      end
   end

endmodule
